// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receive-controller state encoding, minimum oversampling ratio and
// the bit-counter width helper shared by the controller and its counter block.
package uart_rx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
   localparam int MIN_PRESCALE = 4;
   function automatic int bcw(input int data_width);
      return $clog2(data_width + 4);
   endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversample edge counter wrapping at p_i-1 and the in-frame bit
// index it advances; clear dominates enable.
module uart_rx_edge_bit_cnt #(
   parameter int PRESCALE_W = 6,
   parameter int BCW        = 4
) (
   input  logic                  clk_RX,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [PRESCALE_W-1:0] p_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [BCW-1:0]        bit_cnt_o,
   output logic                  bit_end_o
);
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [BCW-1:0]        bit_q, bit_d;
   assign bit_end_o  = edge_q == p_i - 1'b1;
   assign edge_cnt_o = edge_q;
   assign bit_cnt_o  = bit_q;
   always_comb begin
      edge_d = clr_i ? '0 : !en_i ? edge_q : bit_end_o ? '0 : edge_q + 1'b1;
      bit_d  = clr_i ? '0 : (en_i && bit_end_o) ? bit_q + 1'b1 : bit_q;
   end
   always_ff @(posedge clk_RX or negedge rst)
      if (!rst) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame FSM with deserialiser, parity and stop checks.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_frame_ctrl import uart_rx_pkg::*; #(
   parameter  int DATA_WIDTH = 8,
   parameter  int STOP_BITS  = 1,
   parameter  int PRESCALE_W = 6,
   localparam int BCW        = bcw(DATA_WIDTH)
) (
   input  logic                  clk_RX,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  sampled_bit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  dat_samp_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BCW-1:0]        bit_cnt,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  brk_det
);
   localparam logic [BCW-1:0] LAST_NO_PAR = BCW'(DATA_WIDTH + STOP_BITS);
   rx_state_e             state_q, state_d;
   logic [PRESCALE_W-1:0] p_q, p_d, p_even, p_eff;
   logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
   logic                  acc_q, acc_d, par_bad_q, par_bad_d, stp_bad_q, stp_bad_d;
   logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic                  take, bit_end;
   logic [BCW-1:0]        last_bit;
   assign p_even      = {prescale[PRESCALE_W-1:1], 1'b0};
   assign p_eff       = p_even < PRESCALE_W'(MIN_PRESCALE) ? PRESCALE_W'(MIN_PRESCALE) : p_even;
   assign take        = edge_cnt == (p_q >> 1) + 1'b1;
   assign last_bit    = LAST_NO_PAR + BCW'(par_en_q);
   assign dat_samp_en = state_q != IDLE;
   assign p_data      = p_data_q;
   assign data_valid  = dv_q;
   assign par_err     = pe_q;
   assign stp_err     = se_q;
   // BREAK is idle-like for the counters so they cannot run past the frame
   uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W), .BCW(BCW)) u_cnt (
      .clk_RX(clk_RX), .rst(rst), .clr_i(state_d == IDLE || state_d == BREAK),
      .en_i(state_q != IDLE), .p_i(p_q), .edge_cnt_o(edge_cnt), .bit_cnt_o(bit_cnt),
      .bit_end_o(bit_end)
   );
`ifdef UART_RX_BREAK_DET_EN
   logic zero_q, zero_d, bk_q, bk_d;
   assign brk_det = bk_q;
`else
   assign brk_det = 1'b0;
`endif
   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      shift_d   = shift_q;
      acc_d     = acc_q;
      par_bad_d = par_bad_q;
      stp_bad_d = stp_bad_q;
      p_data_d  = p_data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      bk_d      = 1'b0;
      zero_d    = (take && (state_q == DATA || state_q == PARITY || state_q == STOP))
                  ? zero_q && !sampled_bit : zero_q;
`endif
      case (state_q)
         IDLE: if (!rx_in) begin
            state_d   = START;
            p_d       = p_eff;
            par_en_d  = par_en;
            par_typ_d = par_typ;
            acc_d     = 1'b0;
            par_bad_d = 1'b0;
            stp_bad_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_d    = 1'b1;
`endif
         end
         START: state_d = (take && sampled_bit) ? IDLE : bit_end ? DATA : START;
         DATA: begin
            if (take) begin
               shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               acc_d   = acc_q ^ sampled_bit;
            end
            if (bit_end && bit_cnt == BCW'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (take) par_bad_d = sampled_bit != (acc_q ^ par_typ_q);
            if (bit_end) state_d = STOP;
         end
         STOP: if (take) begin
            stp_bad_d = stp_bad_q | !sampled_bit;
            // frame ends at the mid-stop sample so the next start edge is not missed
            if (bit_cnt == last_bit) begin
               state_d = IDLE;
               dv_d    = !par_bad_q && !stp_bad_d;
               pe_d    = par_bad_q;
               se_d    = stp_bad_d;
`ifdef UART_RX_BREAK_DET_EN
               if (zero_d) begin
                  state_d = BREAK;
                  dv_d    = 1'b0;
                  pe_d    = 1'b0;
                  se_d    = 1'b0;
                  bk_d    = 1'b1;
               end
`endif
               p_data_d = dv_d ? shift_q : p_data_q;
            end
         end
`ifdef UART_RX_BREAK_DET_EN
         BREAK: if (rx_in) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_RX or negedge rst)
      if (!rst) begin
         state_q   <= IDLE;
         p_q       <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         shift_q   <= '0;
         acc_q     <= 1'b0;
         par_bad_q <= 1'b0;
         stp_bad_q <= 1'b0;
         p_data_q  <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         shift_q   <= shift_d;
         acc_q     <= acc_d;
         par_bad_q <= par_bad_d;
         stp_bad_q <= stp_bad_d;
         p_data_q  <= p_data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
`ifdef UART_RX_BREAK_DET_EN
   always_ff @(posedge clk_RX or negedge rst)
      if (!rst) begin
         zero_q <= 1'b0;
         bk_q   <= 1'b0;
      end else begin
         zero_q <= zero_d;
         bk_q   <= bk_d;
      end
`endif
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames into a 1-stop and a 2-stop receive controller,
// with pulse counters sampled on the falling clock edge.
module tb_uart_rx_frame_ctrl;
   logic       clk_RX = 1'b0;
   logic       rst;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic [5:0] prescale = 6'd8;
   logic       par_en = 1'b0, par_typ = 1'b0;
   logic       dse_a, dv_a, pe_a, se_a, bk_a, dse_b, dv_b, pe_b, se_b, bk_b;
   logic [5:0] ec_a, ec_b;
   logic [3:0] bc_a, bc_b;
   logic [7:0] pd_a, pd_b;
   int cyc = 0, passes = 0, fails = 0, total = 0, f_c0 = 0;
   int n_dv_a = 0, n_pe_a = 0, n_se_a = 0, n_bk_a = 0, last_dv_a = 0;
   int n_dv_b = 0, n_pe_b = 0, n_se_b = 0;
   int s_dv, s_pe, s_se, s_bk;

   uart_rx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1), .PRESCALE_W(6)) dut_a (
      .clk_RX(clk_RX), .rst(rst), .rx_in(rx_a), .sampled_bit(rx_a), .prescale(prescale),
      .par_en(par_en), .par_typ(par_typ), .dat_samp_en(dse_a), .edge_cnt(ec_a),
      .bit_cnt(bc_a), .p_data(pd_a), .data_valid(dv_a), .par_err(pe_a), .stp_err(se_a),
      .brk_det(bk_a));
   uart_rx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2), .PRESCALE_W(6)) dut_b (
      .clk_RX(clk_RX), .rst(rst), .rx_in(rx_b), .sampled_bit(rx_b), .prescale(prescale),
      .par_en(par_en), .par_typ(par_typ), .dat_samp_en(dse_b), .edge_cnt(ec_b),
      .bit_cnt(bc_b), .p_data(pd_b), .data_valid(dv_b), .par_err(pe_b), .stp_err(se_b),
      .brk_det(bk_b));

   always #5 clk_RX = ~clk_RX;
   always @(posedge clk_RX) cyc <= cyc + 1;
   always @(negedge clk_RX) begin
      n_dv_a <= n_dv_a + int'(dv_a);
      n_pe_a <= n_pe_a + int'(pe_a);
      n_se_a <= n_se_a + int'(se_a);
      n_bk_a <= n_bk_a + int'(bk_a);
      n_dv_b <= n_dv_b + int'(dv_b);
      n_pe_b <= n_pe_b + int'(pe_b);
      n_se_b <= n_se_b + int'(se_b);
      if (dv_a) last_dv_a <= cyc;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // call at a falling edge; each line bit is held for p clock cycles
   task automatic send(input bit to_b, input logic [7:0] d, input int p, input bit with_par,
                       input bit par_bit, input logic [1:0] stops, input int nstop);
      logic fb[$];
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(d[i]);
      if (with_par) fb.push_back(par_bit);
      for (int i = 0; i < nstop; i++) fb.push_back(stops[i]);
      f_c0 = cyc;
      foreach (fb[i]) begin
         if (to_b) rx_b = fb[i];
         else rx_a = fb[i];
         repeat (p) @(negedge clk_RX);
      end
   endtask

   task automatic snap();
      s_dv = n_dv_a;
      s_pe = n_pe_a;
      s_se = n_se_a;
      s_bk = n_bk_a;
   endtask

   initial begin
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk_RX);
      chk("rst_dse", dse_a, 0);
      chk("rst_edge", ec_a, 0);
      chk("rst_bit", bc_a, 0);
      chk("rst_pdata", pd_a, 0);
      chk("rst_dv", dv_a, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk_RX);
      snap();
      send(0, 8'hA5, 8, 0, 0, 2'b11, 1);
      repeat (5) @(negedge clk_RX);
      chk("t1_dv_cnt", n_dv_a - s_dv, 1);
      chk("t1_dv_cyc", last_dv_a - f_c0, 79);
      chk("t1_pdata", pd_a, 8'hA5);
      chk("t1_errs", (n_pe_a - s_pe) + (n_se_a - s_se), 0);
      snap();
      prescale = 6'd16;
      par_en   = 1'b1;
      par_typ  = 1'b0;
      send(0, 8'h3C, 16, 1, 1, 2'b11, 1);
      prescale = 6'd8;
      par_en   = 1'b0;
      repeat (5) @(negedge clk_RX);
      chk("t2_pe_cnt", n_pe_a - s_pe, 1);
      chk("t2_dv_cnt", n_dv_a - s_dv, 0);
      chk("t2_se_cnt", n_se_a - s_se, 0);
      chk("t2_pdata", pd_a, 8'hA5);
      snap();
      rx_a = 1'b0;
      @(negedge clk_RX);
      chk("t3_start_dse", dse_a, 1);
      chk("t3_start_edge", ec_a, 0);
      repeat (2) @(negedge clk_RX);
      rx_a = 1'b1;
      repeat (12) @(negedge clk_RX);
      chk("t3_dse", dse_a, 0);
      chk("t3_edge", ec_a, 0);
      chk("t3_bit", bc_a, 0);
      chk("t3_pulses", (n_dv_a - s_dv) + (n_pe_a - s_pe) + (n_se_a - s_se), 0);
      send(1, 8'h81, 8, 0, 0, 2'b01, 2);
      rx_b = 1'b1;
      repeat (20) @(negedge clk_RX);
      chk("t4_se_cnt", n_se_b, 1);
      chk("t4_dv_cnt", n_dv_b, 0);
      chk("t4_pe_cnt", n_pe_b, 0);
      chk("t4_pdata", pd_b, 0);
      snap();
      send(0, 8'h55, 8, 0, 0, 2'b11, 1);
      chk("t5_pdata1", pd_a, 8'h55);
      chk("t5_dv_cyc1", last_dv_a - f_c0, 79);
      send(0, 8'h0F, 8, 0, 0, 2'b11, 1);
      repeat (5) @(negedge clk_RX);
      chk("t5_pdata2", pd_a, 8'h0F);
      chk("t5_dv_cyc2", last_dv_a - f_c0, 79);
      chk("t5_dv_cnt", n_dv_a - s_dv, 2);
      chk("t5_errs", (n_pe_a - s_pe) + (n_se_a - s_se), 0);
      snap();
      rx_a = 1'b0;
      repeat (240) @(negedge clk_RX);
      rx_a = 1'b1;
      repeat (30) @(negedge clk_RX);
`ifdef UART_RX_BREAK_DET_EN
      chk("t6_bk_cnt", n_bk_a - s_bk, 1);
      chk("t6_se_cnt", n_se_a - s_se, 0);
`else
      chk("t6_bk_cnt", n_bk_a - s_bk, 0);
      chk("t6_se_cnt", n_se_a - s_se, 3);
`endif
      chk("t6_dv_cnt", n_dv_a - s_dv, 0);
      chk("t6_pdata", pd_a, 8'h0F);
      chk("t6_dse", dse_a, 0);
      snap();
      rx_a = 1'b0;
      repeat (30) @(negedge clk_RX);
      chk("t7_mid_dse", dse_a, 1);
      rst = 1'b0;
      @(negedge clk_RX);
      chk("t7_rst_dse", dse_a, 0);
      chk("t7_rst_edge", ec_a, 0);
      chk("t7_rst_pdata", pd_a, 0);
      rx_a = 1'b1;
      rst  = 1'b1;
      repeat (5) @(negedge clk_RX);
      chk("t7_pulses", (n_dv_a - s_dv) + (n_pe_a - s_pe) + (n_se_a - s_se), 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
